// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each winning operation is registered into a single EX stage, then its result lands in a per-requester response slot.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_srca,
  input  logic [WIDTH-1:0] req0_srcb,
  input  logic [WIDTH-1:0] req1_srca,
  input  logic [WIDTH-1:0] req1_srcb,
  input  logic [2:0]       req0_ctrl,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp0_zero,
  output logic             rsp1_zero
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready never looks at operand data, and rsp data holds steady until its transfer.

  logic             ex_valid;
  logic             ex_id;
  logic [WIDTH-1:0] ex_srca;
  logic [WIDTH-1:0] ex_srcb;
  logic [2:0]       ex_ctrl;
  logic             last_grant;

  logic [1:0] slot_free;
  logic [1:0] eligible;
  logic [1:0] grant;

  always_comb begin
    slot_free = ~rsp_valid | rsp_ready;
    // One operation outstanding per requester: not in EX, and the slot is empty or emptying now.
    eligible[0] = req_valid[0] && !(ex_valid && (ex_id == 1'b0)) && slot_free[0];
    eligible[1] = req_valid[1] && !(ex_valid && (ex_id == 1'b1)) && slot_free[1];
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  assign req_ready = reset ? 2'b00 : grant;

  assign alu_srca = ex_srca;
  assign alu_srcb = ex_srcb;
  assign alu_ctrl = ex_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_id       <= 1'b0;
      ex_srca     <= '0;
      ex_srcb     <= '0;
      ex_ctrl     <= 3'b000;
      last_grant  <= 1'b1;
      rsp_valid   <= 2'b00;
      rsp0_result <= '0;
      rsp1_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_zero   <= 1'b0;
    end else begin
      ex_valid <= |grant;
      if (|grant) begin
        ex_id      <= grant[1];
        ex_srca    <= grant[1] ? req1_srca : req0_srca;
        ex_srcb    <= grant[1] ? req1_srcb : req0_srcb;
        ex_ctrl    <= grant[1] ? req1_ctrl : req0_ctrl;
        last_grant <= grant[1];
      end

      // A capture into a slot takes priority over releasing it on the same edge.
      if (ex_valid && (ex_id == 1'b0)) begin
        rsp_valid[0] <= 1'b1;
        rsp0_result  <= alu_result;
        rsp0_zero    <= alu_zero;
      end else if (rsp_valid[0] && rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end

      if (ex_valid && (ex_id == 1'b1)) begin
        rsp_valid[1] <= 1'b1;
        rsp1_result  <= alu_result;
        rsp1_zero    <= alu_zero;
      end else if (rsp_valid[1] && rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

endmodule
